// File: rtl/pulse_inst_scheduler_pkg.sv
// pulse_inst_scheduler_pkg
//   Shared definitions for the pulse instruction scheduler:
//   - state_e: 3-bit sequencer state encoding
//   - DirectionLsb: bit offset of the direction field within an instruction-list
//     entry; the start time sits directly above the direction field.
package pulse_inst_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFetch    = 3'd1,
        StWaitData = 3'd2,
        StWaitTime = 3'd3,
        StIssue    = 3'd4
    } state_e;

    localparam int unsigned DirectionLsb = 0;

endpackage

// File: rtl/pulse_inst_scheduler_occupancy.sv
// pulse_inst_scheduler_occupancy
//   Up/down occupancy counter for the instruction list. It counts snooped decoder
//   writes up and issue handshakes down, saturates at the list depth and flags a
//   sticky overflow when a write lands on a full list.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          synchronous flush (count and flag to 0, coincident write dropped)
//   inc            snooped write strobe
//   dec            issue handshake
//   count          entries currently held, 0..2**ADDR_WIDTH
//   overflow_err   sticky overflow flag
module pulse_inst_scheduler_occupancy #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    input  logic                dec,
    output logic [ADDR_WIDTH:0] count,
    output logic                overflow_err
);

    localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            // A write and a handshake in the same cycle cancel out, even when full,
            // because the handshake frees the slot the write lands in.
            unique case ({inc, dec})
                2'b10: begin
                    if (count == Depth) begin
                        overflow_err <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                2'b01: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pulse_inst_scheduler.sv
// pulse_inst_scheduler
//   Drains the instruction list in write order and hands each pulse to the pulse
//   generator once the global counter reaches the entry's start time. Occupancy is
//   tracked by snooping the decoder write strobe.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   glb_counter_in        global time
//   clear_in              synchronous flush (paired with a decoder reset)
//   inst_list_wr_en_in    snooped decoder write enable
//   inst_list_rd_en/addr  instruction-list read request (registered)
//   inst_list_rd_data     read data {start_time, direction}, valid 1 cycle after rd_en
//   pulse_valid_out       pulse request, held until pulse_ready_in
//   pulse_direction_out   direction of the requested pulse
//   pulse_ready_in        pulse generator accept
//   pending_count_out     unconsumed entries
//   late_err_out          sticky: an entry was issued after its start time
//   overflow_err_out      sticky: a write arrived while the list was full
module pulse_inst_scheduler
    import pulse_inst_scheduler_pkg::*;
#(
    parameter int unsigned GLB_COUNTER_WIDTH    = 24,
    parameter int unsigned INST_LIST_ADDR_WIDTH = 5,
    parameter int unsigned INST_LIST_DATA_WIDTH = 26,
    parameter int unsigned DIRECTION_WIDTH      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [GLB_COUNTER_WIDTH-1:0]    glb_counter_in,
    input  logic                            clear_in,
    input  logic                            inst_list_wr_en_in,
    output logic                            inst_list_rd_en,
    output logic [INST_LIST_ADDR_WIDTH-1:0] inst_list_rd_addr,
    input  logic [INST_LIST_DATA_WIDTH-1:0] inst_list_rd_data,
    output logic                            pulse_valid_out,
    output logic [DIRECTION_WIDTH-1:0]      pulse_direction_out,
    input  logic                            pulse_ready_in,
    output logic [INST_LIST_ADDR_WIDTH:0]   pending_count_out,
    output logic                            late_err_out,
    output logic                            overflow_err_out
);

    localparam int unsigned TimeLsb = DirectionLsb + DIRECTION_WIDTH;
    localparam logic [INST_LIST_ADDR_WIDTH:0] CountOne = {{INST_LIST_ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                          state;
    logic [INST_LIST_ADDR_WIDTH-1:0] rd_ptr;
    logic [GLB_COUNTER_WIDTH-1:0]    entry_time;
    logic [DIRECTION_WIDTH-1:0]      entry_dir;
    logic [INST_LIST_ADDR_WIDTH:0]   count;
    logic [GLB_COUNTER_WIDTH-1:0]    time_diff;
    logic                            entry_late;
    logic                            entry_due;
    logic                            handshake;
    logic                            more_pending;

    assign handshake = pulse_valid_out & pulse_ready_in;

    // Modular difference: MSB set means the start time is already behind us.
    assign time_diff  = entry_time - glb_counter_in;
    assign entry_late = time_diff[GLB_COUNTER_WIDTH-1];
    assign entry_due  = (time_diff == '0) || entry_late;

    // Entries left after the current handshake; a coincident write keeps it nonzero.
    assign more_pending = (count != CountOne) || inst_list_wr_en_in;

    assign pending_count_out = count;

    pulse_inst_scheduler_occupancy #(
        .ADDR_WIDTH(INST_LIST_ADDR_WIDTH)
    ) u_occupancy (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear_in),
        .inc         (inst_list_wr_en_in),
        .dec         (handshake),
        .count       (count),
        .overflow_err(overflow_err_out)
    );

    // Outputs are registered and set on entry into the state that owns them, so
    // rd_en is high exactly during FETCH and valid exactly during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= StIdle;
            rd_ptr              <= '0;
            entry_time          <= '0;
            entry_dir           <= '0;
            inst_list_rd_en     <= 1'b0;
            inst_list_rd_addr   <= '0;
            pulse_valid_out     <= 1'b0;
            pulse_direction_out <= '0;
            late_err_out        <= 1'b0;
        end else if (clear_in) begin
            state               <= StIdle;
            rd_ptr              <= '0;
            entry_time          <= '0;
            entry_dir           <= '0;
            inst_list_rd_en     <= 1'b0;
            inst_list_rd_addr   <= '0;
            pulse_valid_out     <= 1'b0;
            pulse_direction_out <= '0;
            late_err_out        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (count != '0) begin
                        state             <= StFetch;
                        inst_list_rd_en   <= 1'b1;
                        inst_list_rd_addr <= rd_ptr;
                    end
                end
                StFetch: begin
                    inst_list_rd_en <= 1'b0;
                    state           <= StWaitData;
                end
                StWaitData: begin
                    entry_time <= inst_list_rd_data[TimeLsb +: GLB_COUNTER_WIDTH];
                    entry_dir  <= inst_list_rd_data[DirectionLsb +: DIRECTION_WIDTH];
                    state      <= StWaitTime;
                end
                StWaitTime: begin
                    if (entry_due) begin
                        state               <= StIssue;
                        pulse_valid_out     <= 1'b1;
                        pulse_direction_out <= entry_dir;
                        if (entry_late) begin
                            late_err_out <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (pulse_ready_in) begin
                        pulse_valid_out <= 1'b0;
                        rd_ptr          <= rd_ptr + 1'b1;
                        if (more_pending) begin
                            state             <= StFetch;
                            inst_list_rd_en   <= 1'b1;
                            inst_list_rd_addr <= rd_ptr + 1'b1;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_inst_scheduler.sv
// Self-checking bench for pulse_inst_scheduler: a table of single-entry vectors
// followed by hand-written multi-cycle sequences. Expected pulses go into a
// scoreboard queue when an entry is written and are compared on each handshake.
module tb_pulse_inst_scheduler;

    localparam int unsigned GW    = 24;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 26;
    localparam int unsigned Depth = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [GW-1:0] glb_counter_in = '0;
    logic          clear_in = 1'b0;
    logic          inst_list_wr_en_in = 1'b0;
    logic          inst_list_rd_en;
    logic [AW-1:0] inst_list_rd_addr;
    logic [DW-1:0] inst_list_rd_data = '0;
    logic          pulse_valid_out;
    logic [1:0]    pulse_direction_out;
    logic          pulse_ready_in = 1'b1;
    logic [AW:0]   pending_count_out;
    logic          late_err_out;
    logic          overflow_err_out;

    always #5 clk = ~clk;

    pulse_inst_scheduler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .glb_counter_in     (glb_counter_in),
        .clear_in           (clear_in),
        .inst_list_wr_en_in (inst_list_wr_en_in),
        .inst_list_rd_en    (inst_list_rd_en),
        .inst_list_rd_addr  (inst_list_rd_addr),
        .inst_list_rd_data  (inst_list_rd_data),
        .pulse_valid_out    (pulse_valid_out),
        .pulse_direction_out(pulse_direction_out),
        .pulse_ready_in     (pulse_ready_in),
        .pending_count_out  (pending_count_out),
        .late_err_out       (late_err_out),
        .overflow_err_out   (overflow_err_out)
    );

    typedef struct {
        logic [GW-1:0] fire;
        logic [1:0]    dir;
    } exp_t;

    typedef struct {
        logic [GW-1:0] c0;
        logic [GW-1:0] t;
        logic [1:0]    dir;
        logic [GW-1:0] fire;
        logic          late;
    } vec_t;

    logic [DW-1:0] mem [Depth];
    exp_t          sb[$];
    vec_t          vecs[6];
    int            wp = 0;
    int            tests = 0;
    int            fails = 0;
    int            valid_cycles = 0;
    int            fetches = 0;
    logic [AW-1:0] last_fetch_addr = '0;
    logic [GW-1:0] last_fetch_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake monitor: counter and direction compared against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pulse_valid_out && pulse_ready_in) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse at counter %0d expected none",
                         glb_counter_in);
            end else begin
                e = sb.pop_front();
                check("pulse_time", 64'(glb_counter_in), 64'(e.fire));
                check("pulse_dir", 64'(pulse_direction_out), 64'(e.dir));
            end
        end
    end

    // One clock: the synchronous memory model answers last cycle's read, the global
    // counter advances, and fetches/valid cycles are recorded.
    task automatic cyc();
        logic          r;
        logic [AW-1:0] a;
        r = inst_list_rd_en;
        a = inst_list_rd_addr;
        @(posedge clk);
        #1;
        if (r) inst_list_rd_data = mem[a];
        glb_counter_in = glb_counter_in + 1'b1;
        inst_list_wr_en_in = 1'b0;
        if (inst_list_rd_en) begin
            fetches++;
            last_fetch_addr = inst_list_rd_addr;
            last_fetch_cnt  = glb_counter_in;
        end
        if (pulse_valid_out) valid_cycles++;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        cyc();
        clear_in = 1'b0;
        wp = 0;
        sb.delete();
    endtask

    task automatic write_entry(input logic [GW-1:0] t, input logic [1:0] d,
                               input bit expect_pulse, input logic [GW-1:0] fire);
        exp_t e;
        mem[wp] = {t, d};
        wp = (wp + 1) % Depth;
        inst_list_wr_en_in = 1'b1;
        if (expect_pulse) begin
            e.fire = fire;
            e.dir  = d;
            sb.push_back(e);
        end
        cyc();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: %0d pulses outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!pulse_valid_out && n < budget) begin
            cyc();
            n++;
        end
        if (!pulse_valid_out) begin
            tests++;
            fails++;
            $display("FAIL %s: pulse_valid_out got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 64'(inst_list_rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(inst_list_rd_addr), 64'd0);
        check({tag, "_valid"}, 64'(pulse_valid_out), 64'd0);
        check({tag, "_dir"}, 64'(pulse_direction_out), 64'd0);
        check({tag, "_pending"}, 64'(pending_count_out), 64'd0);
        check({tag, "_late"}, 64'(late_err_out), 64'd0);
        check({tag, "_overflow"}, 64'(overflow_err_out), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GW-1:0] c;

        // Expected fire counter: entry_time+1 when the entry reaches WAIT_TIME in
        // time (write-cycle counter + 4 <= entry_time), else write counter + 5, late.
        vecs[0] = '{c0: 24'd90,       t: 24'd100,  dir: 2'b10, fire: 24'd101,  late: 1'b0};
        vecs[1] = '{c0: 24'd60,       t: 24'd50,   dir: 2'b01, fire: 24'd65,   late: 1'b1};
        vecs[2] = '{c0: 24'd60,       t: 24'd64,   dir: 2'b11, fire: 24'd65,   late: 1'b0};
        vecs[3] = '{c0: 24'd60,       t: 24'd63,   dir: 2'b00, fire: 24'd65,   late: 1'b1};
        vecs[4] = '{c0: 24'hFFFFFE,   t: 24'd2,    dir: 2'b10, fire: 24'd3,    late: 1'b0};
        vecs[5] = '{c0: 24'd10,       t: 24'd1000, dir: 2'b01, fire: 24'd1001, late: 1'b0};

        // Reset state
        repeat (2) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Single-entry vectors
        for (int i = 0; i < 6; i++) begin
            do_clear();
            glb_counter_in = vecs[i].c0;
            valid_cycles = 0;
            fetches = 0;
            write_entry(vecs[i].t, vecs[i].dir, 1'b1, vecs[i].fire);
            wait_drain(2000, "vec_drain");
            cyc();
            check("vec_valid_cycles", 64'(valid_cycles), 64'd1);
            check("vec_fetches", 64'(fetches), 64'd1);
            check("vec_fetch_addr", 64'(last_fetch_addr), 64'd0);
            check("vec_pending", 64'(pending_count_out), 64'd0);
            check("vec_valid_low", 64'(pulse_valid_out), 64'd0);
            check("vec_overflow", 64'(overflow_err_out), 64'd0);
            repeat (3) cyc();
            check("vec_late_sticky", 64'(late_err_out), 64'(vecs[i].late));
        end

        // Two entries back to back
        do_clear();
        glb_counter_in = 24'd190;
        fetches = 0;
        valid_cycles = 0;
        write_entry(24'd200, 2'b10, 1'b1, 24'd201);
        write_entry(24'd204, 2'b01, 1'b1, 24'd205);
        wait_drain(100, "pair_drain");
        cyc();
        check("pair_fetches", 64'(fetches), 64'd2);
        check("pair_second_fetch_time", 64'(last_fetch_cnt), 64'd202);
        check("pair_second_fetch_addr", 64'(last_fetch_addr), 64'd1);
        check("pair_valid_cycles", 64'(valid_cycles), 64'd2);
        check("pair_late", 64'(late_err_out), 64'd0);
        c = glb_counter_in;
        write_entry(c + 24'd10, 2'b11, 1'b1, c + 24'd11);
        wait_drain(100, "pair_third_drain");
        cyc();
        check("pair_rd_ptr_after", 64'(last_fetch_addr), 64'd2);

        // Backpressure: ready low for 3 ISSUE cycles
        do_clear();
        glb_counter_in = 24'd290;
        pulse_ready_in = 1'b0;
        write_entry(24'd300, 2'b11, 1'b1, 24'd304);
        wait_valid(100, "bp_valid");
        check("bp_rise_time", 64'(glb_counter_in), 64'd301);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 64'(pulse_valid_out), 64'd1);
            check("bp_hold_dir", 64'(pulse_direction_out), 64'd3);
            check("bp_hold_pending", 64'(pending_count_out), 64'd1);
            cyc();
        end
        pulse_ready_in = 1'b1;
        check("bp_hs_valid", 64'(pulse_valid_out), 64'd1);
        check("bp_hs_pending", 64'(pending_count_out), 64'd1);
        cyc();
        check("bp_after_valid", 64'(pulse_valid_out), 64'd0);
        check("bp_after_pending", 64'(pending_count_out), 64'd0);
        check("bp_scoreboard_left", 64'(sb.size()), 64'd0);

        // Overflow: 33 writes, nothing due
        do_clear();
        glb_counter_in = 24'd1000;
        for (int i = 0; i < 32; i++) begin
            write_entry(24'h700000, 2'(i % 4), 1'b0, '0);
        end
        check("ovf_full_pending", 64'(pending_count_out), 64'd32);
        check("ovf_full_flag", 64'(overflow_err_out), 64'd0);
        write_entry(24'h700000, 2'b00, 1'b0, '0);
        check("ovf_sat_pending", 64'(pending_count_out), 64'd32);
        check("ovf_flag", 64'(overflow_err_out), 64'd1);
        do_clear();
        check_all_zero("ovf_clear");

        // Wrap: 34 entries drained one at a time
        for (int i = 0; i < 34; i++) begin
            c = glb_counter_in;
            write_entry(c + 24'd4, 2'(i % 4), 1'b1, c + 24'd5);
            wait_drain(50, "wrap_drain");
            cyc();
            check("wrap_fetch_addr", 64'(last_fetch_addr), 64'(i % 32));
        end
        check("wrap_late", 64'(late_err_out), 64'd0);

        // Asynchronous reset during ISSUE
        pulse_ready_in = 1'b0;
        c = glb_counter_in;
        write_entry(c + 24'd10, 2'b01, 1'b1, c + 24'd11);
        wait_valid(50, "rst_valid");
        check("rst_pre_valid", 64'(pulse_valid_out), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        sb.delete();
        wp = 0;
        pulse_ready_in = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        check_all_zero("rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
